// File: rtl/if_id_stall_ctrl.sv
// Fetch-side pipeline control: owns the PC and IF/ID register, reacts to stall/flush,
// drives the ID/EX bubble select and keeps saturating statistics plus a stall watchdog.
module if_id_stall_ctrl #(
  parameter int unsigned           PC_WIDTH   = 32,
  parameter int unsigned           INSN_WIDTH = 32,
  parameter int unsigned           PC_STEP    = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN   = INSN_WIDTH'(32'h0000_0013),
  parameter int unsigned           CNT_WIDTH  = 16,
  parameter int unsigned           MAX_STALL  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic [INSN_WIDTH-1:0] imem_instr,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [PC_WIDTH-1:0]   if_id_pc_next,
  output logic [INSN_WIDTH-1:0] if_id_instr,
  output logic                  if_id_valid,
  output logic                  id_ex_bubble,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count,
  output logic                  stall_timeout
);

  localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(PC_STEP);
  localparam int unsigned         SRUN_W   = $clog2(MAX_STALL + 1);
  localparam logic [SRUN_W-1:0]   SRUN_MAX = SRUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_STALLED
  } state_t;

  state_t                  state_reg,    state_next;
  logic [PC_WIDTH-1:0]     pc_reg,       pc_next;
  logic [PC_WIDTH-1:0]     ipc_reg,      ipc_next;
  logic [PC_WIDTH-1:0]     seq_pc_reg,   seq_pc_next;
  logic [INSN_WIDTH-1:0]   instr_reg,    instr_next;
  logic                    valid_reg,    valid_next;
  logic [SRUN_W-1:0]       srun_reg,     srun_next;
  logic                    timeout_reg,  timeout_next;

  // Exactly one of these is high when enabled; flush dominates stall.
  logic act_flush, act_stall, act_adv;
  assign act_flush = enable & flush;
  assign act_stall = enable & stall & ~flush;
  assign act_adv   = enable & ~stall & ~flush;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    ipc_next    = ipc_reg;
    seq_pc_next = seq_pc_reg;
    instr_next  = instr_reg;
    valid_next  = valid_reg;
    srun_next   = srun_reg;
    if (act_flush) begin
      pc_next    = branch_target;
      instr_next = NOP_INSN;
      valid_next = 1'b0;
      srun_next  = '0;
      state_next = (state_reg == ST_FILL) ? ST_FILL : ST_RUN;
    end else if (act_stall) begin
      srun_next  = (srun_reg == SRUN_MAX) ? srun_reg : srun_reg + SRUN_W'(1);
      state_next = ST_STALLED;
    end else if (act_adv) begin
      ipc_next    = pc_reg;
      seq_pc_next = pc_reg + STEP;
      instr_next  = imem_instr;
      valid_next  = 1'b1;
      pc_next     = pc_reg + STEP;
      srun_next   = '0;
      state_next  = ST_RUN;
    end
    // Sticky: once the run of stalls hits the limit only reset clears it.
    timeout_next = timeout_reg | (srun_next == SRUN_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_FILL;
      pc_reg      <= RESET_PC;
      ipc_reg     <= '0;
      seq_pc_reg  <= '0;
      instr_reg   <= NOP_INSN;
      valid_reg   <= 1'b0;
      srun_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ipc_reg     <= ipc_next;
      seq_pc_reg  <= seq_pc_next;
      instr_reg   <= instr_next;
      valid_reg   <= valid_next;
      srun_reg    <= srun_next;
      timeout_reg <= timeout_next;
    end
  end

  // Index 0 counts stall cycles, index 1 counts flushes; both stick at all-ones.
  logic [1:0] stat_inc;
  assign stat_inc = {act_flush, act_stall};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && !(&cnt_reg)) begin
        cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign pc_out        = pc_reg;
  assign if_id_pc      = ipc_reg;
  assign if_id_pc_next = seq_pc_reg;
  assign if_id_instr   = instr_reg;
  assign if_id_valid   = valid_reg;
  assign id_ex_bubble  = enable & ~reset & (flush | stall);
  assign stall_count   = g_stat[0].cnt_reg;
  assign flush_count   = g_stat[1].cnt_reg;
  assign stall_timeout = timeout_reg;

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Self-checking bench for if_id_stall_ctrl: a 32-bit instance for the main scenarios and
// an 8-bit / 2-bit-counter instance for PC wrap and counter saturation.
module tb_if_id_stall_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        reset, enable, stall, flush;
  logic [31:0] branch_target, imem_instr;
  logic [31:0] pc_out, if_id_pc, if_id_pc_next, if_id_instr;
  logic        if_id_valid, id_ex_bubble, stall_timeout;
  logic [15:0] stall_count, flush_count;

  // Narrow instance
  logic        b_reset, b_stall, b_flush;
  logic [7:0]  b_bt, b_pc, b_ipc, b_ipcn;
  logic [31:0] b_instr;
  logic [31:0] b_imem;
  logic        b_valid, b_bubble, b_tout;
  logic [1:0]  b_scnt, b_fcnt;

  function automatic logic [31:0] imem_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr = imem_of(pc_out);
  assign b_imem     = 32'h0000_0001;

  if_id_stall_ctrl #(
    .PC_WIDTH(32), .INSN_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h100),
    .NOP_INSN(32'h0000_0013), .CNT_WIDTH(16), .MAX_STALL(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
    .branch_target(branch_target), .imem_instr(imem_instr),
    .pc_out(pc_out), .if_id_pc(if_id_pc), .if_id_pc_next(if_id_pc_next),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .id_ex_bubble(id_ex_bubble),
    .stall_count(stall_count), .flush_count(flush_count), .stall_timeout(stall_timeout)
  );

  if_id_stall_ctrl #(
    .PC_WIDTH(8), .INSN_WIDTH(32), .PC_STEP(4), .RESET_PC(8'hF8),
    .NOP_INSN(32'h0000_0013), .CNT_WIDTH(2), .MAX_STALL(1)
  ) dut_b (
    .clk(clk), .reset(b_reset), .enable(1'b1), .stall(b_stall), .flush(b_flush),
    .branch_target(b_bt), .imem_instr(b_imem),
    .pc_out(b_pc), .if_id_pc(b_ipc), .if_id_pc_next(b_ipcn),
    .if_id_instr(b_instr), .if_id_valid(b_valid), .id_ex_bubble(b_bubble),
    .stall_count(b_scnt), .flush_count(b_fcnt), .stall_timeout(b_tout)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ipcn;
    logic [31:0] instr;
    logic        valid;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic        tout;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int tests = 0;
  int fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; stall = 1'b1; flush = 1'b1; branch_target = 32'h40;
    #1;
    tests++; if (id_ex_bubble !== 1'b0) begin fails++; $display("FAIL rst_bubble: got %b expected 0", id_ex_bubble); end
    sb.push_back('{pc:32'h100, ipc:0, ipcn:0, instr:NOP, valid:0, scnt:0, fcnt:0, tout:0});
    tick(); tick();
    e = sb.pop_front();
    $display("[TB] reset: pc=%h valid=%b", pc_out, if_id_valid);
    tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL rst_pc: got %h expected %h", pc_out, e.pc); end
    tests++; if (if_id_pc !== e.ipc) begin fails++; $display("FAIL rst_ipc: got %h expected %h", if_id_pc, e.ipc); end
    tests++; if (if_id_pc_next !== e.ipcn) begin fails++; $display("FAIL rst_ipcn: got %h expected %h", if_id_pc_next, e.ipcn); end
    tests++; if (if_id_instr !== e.instr) begin fails++; $display("FAIL rst_instr: got %h expected %h", if_id_instr, e.instr); end
    tests++; if (if_id_valid !== e.valid) begin fails++; $display("FAIL rst_valid: got %b expected %b", if_id_valid, e.valid); end
    tests++; if (stall_count !== e.scnt) begin fails++; $display("FAIL rst_scnt: got %0d expected %0d", stall_count, e.scnt); end
    tests++; if (flush_count !== e.fcnt) begin fails++; $display("FAIL rst_fcnt: got %0d expected %0d", flush_count, e.fcnt); end
    tests++; if (stall_timeout !== e.tout) begin fails++; $display("FAIL rst_tout: got %b expected %b", stall_timeout, e.tout); end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_advance();
    #1;
    tests++; if (id_ex_bubble !== 1'b0) begin fails++; $display("FAIL adv_bubble: got %b expected 0", id_ex_bubble); end
    tests++; if (if_id_valid !== 1'b0) begin fails++; $display("FAIL adv_first_valid: got %b expected 0", if_id_valid); end
    sb.push_back('{pc:32'h104, ipc:32'h100, ipcn:32'h104, instr:imem_of(32'h100), valid:1, scnt:0, fcnt:0, tout:0});
    sb.push_back('{pc:32'h108, ipc:32'h104, ipcn:32'h108, instr:imem_of(32'h104), valid:1, scnt:0, fcnt:0, tout:0});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      $display("[TB] advance %0d: pc=%h if_id_pc=%h", i, pc_out, if_id_pc);
      tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL adv_pc: got %h expected %h", pc_out, e.pc); end
      tests++; if (if_id_pc !== e.ipc) begin fails++; $display("FAIL adv_ipc: got %h expected %h", if_id_pc, e.ipc); end
      tests++; if (if_id_pc_next !== e.ipcn) begin fails++; $display("FAIL adv_ipcn: got %h expected %h", if_id_pc_next, e.ipcn); end
      tests++; if (if_id_instr !== e.instr) begin fails++; $display("FAIL adv_instr: got %h expected %h", if_id_instr, e.instr); end
      tests++; if (if_id_valid !== e.valid) begin fails++; $display("FAIL adv_valid: got %b expected %b", if_id_valid, e.valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    tests++; if (id_ex_bubble !== 1'b1) begin fails++; $display("FAIL stall_bubble_on: got %b expected 1", id_ex_bubble); end
    sb.push_back('{pc:32'h108, ipc:32'h104, ipcn:32'h108, instr:imem_of(32'h104), valid:1, scnt:1, fcnt:0, tout:0});
    sb.push_back('{pc:32'h10C, ipc:32'h108, ipcn:32'h10C, instr:imem_of(32'h108), valid:1, scnt:1, fcnt:0, tout:0});
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) begin
        stall = 1'b0;
        #1;
        tests++; if (id_ex_bubble !== 1'b0) begin fails++; $display("FAIL stall_bubble_off: got %b expected 0", id_ex_bubble); end
      end
      e = sb.pop_front();
      $display("[TB] stall %0d: pc=%h if_id_pc=%h stall_count=%0d", i, pc_out, if_id_pc, stall_count);
      tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL stall_pc: got %h expected %h", pc_out, e.pc); end
      tests++; if (if_id_pc !== e.ipc) begin fails++; $display("FAIL stall_ipc: got %h expected %h", if_id_pc, e.ipc); end
      tests++; if (if_id_instr !== e.instr) begin fails++; $display("FAIL stall_instr: got %h expected %h", if_id_instr, e.instr); end
      tests++; if (stall_count !== e.scnt) begin fails++; $display("FAIL stall_scnt: got %0d expected %0d", stall_count, e.scnt); end
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; branch_target = 32'h40;
    #1;
    tests++; if (id_ex_bubble !== 1'b1) begin fails++; $display("FAIL flush_bubble: got %b expected 1", id_ex_bubble); end
    sb.push_back('{pc:32'h40, ipc:32'h108, ipcn:32'h10C, instr:NOP, valid:0, scnt:1, fcnt:1, tout:0});
    sb.push_back('{pc:32'h44, ipc:32'h40, ipcn:32'h44, instr:imem_of(32'h40), valid:1, scnt:1, fcnt:1, tout:0});
    for (int i = 0; i < 2; i++) begin
      tick();
      flush = 1'b0;
      e = sb.pop_front();
      $display("[TB] flush %0d: pc=%h valid=%b flush_count=%0d", i, pc_out, if_id_valid, flush_count);
      tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL flush_pc: got %h expected %h", pc_out, e.pc); end
      tests++; if (if_id_pc !== e.ipc) begin fails++; $display("FAIL flush_ipc: got %h expected %h", if_id_pc, e.ipc); end
      tests++; if (if_id_pc_next !== e.ipcn) begin fails++; $display("FAIL flush_ipcn: got %h expected %h", if_id_pc_next, e.ipcn); end
      tests++; if (if_id_instr !== e.instr) begin fails++; $display("FAIL flush_instr: got %h expected %h", if_id_instr, e.instr); end
      tests++; if (if_id_valid !== e.valid) begin fails++; $display("FAIL flush_valid: got %b expected %b", if_id_valid, e.valid); end
      tests++; if (flush_count !== e.fcnt) begin fails++; $display("FAIL flush_fcnt: got %0d expected %0d", flush_count, e.fcnt); end
    end
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; flush = 1'b1; branch_target = 32'h80;
    sb.push_back('{pc:32'h80, ipc:32'h40, ipcn:32'h44, instr:NOP, valid:0, scnt:1, fcnt:2, tout:0});
    sb.push_back('{pc:32'h84, ipc:32'h80, ipcn:32'h84, instr:imem_of(32'h80), valid:1, scnt:1, fcnt:2, tout:0});
    for (int i = 0; i < 2; i++) begin
      tick();
      stall = 1'b0; flush = 1'b0;
      e = sb.pop_front();
      $display("[TB] stall+flush %0d: pc=%h scnt=%0d fcnt=%0d", i, pc_out, stall_count, flush_count);
      tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL sf_pc: got %h expected %h", pc_out, e.pc); end
      tests++; if (if_id_valid !== e.valid) begin fails++; $display("FAIL sf_valid: got %b expected %b", if_id_valid, e.valid); end
      tests++; if (stall_count !== e.scnt) begin fails++; $display("FAIL sf_scnt: got %0d expected %0d", stall_count, e.scnt); end
      tests++; if (flush_count !== e.fcnt) begin fails++; $display("FAIL sf_fcnt: got %0d expected %0d", flush_count, e.fcnt); end
    end
  endtask

  task automatic test_watchdog();
    stall = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{pc:32'h84, ipc:32'h80, ipcn:32'h84, instr:imem_of(32'h80), valid:1,
                     scnt:16'(2 + i), fcnt:2, tout:(i == 3)});
    sb.push_back('{pc:32'h88, ipc:32'h84, ipcn:32'h88, instr:imem_of(32'h84), valid:1, scnt:5, fcnt:2, tout:1});
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 3) stall = 1'b0;
      e = sb.pop_front();
      $display("[TB] watchdog %0d: pc=%h scnt=%0d timeout=%b", i, pc_out, stall_count, stall_timeout);
      tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL wd_pc: got %h expected %h", pc_out, e.pc); end
      tests++; if (stall_count !== e.scnt) begin fails++; $display("FAIL wd_scnt: got %0d expected %0d", stall_count, e.scnt); end
      tests++; if (stall_timeout !== e.tout) begin fails++; $display("FAIL wd_tout: got %b expected %b", stall_timeout, e.tout); end
    end
  endtask

  task automatic test_enable();
    enable = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (id_ex_bubble !== 1'b0) begin fails++; $display("FAIL en_bubble: got %b expected 0", id_ex_bubble); end
      sb.push_back('{pc:32'h88, ipc:32'h84, ipcn:32'h88, instr:imem_of(32'h84), valid:1, scnt:5, fcnt:2, tout:1});
      tick();
      e = sb.pop_front();
      $display("[TB] disabled %0d: pc=%h scnt=%0d", i, pc_out, stall_count);
      tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL en_pc: got %h expected %h", pc_out, e.pc); end
      tests++; if (if_id_pc !== e.ipc) begin fails++; $display("FAIL en_ipc: got %h expected %h", if_id_pc, e.ipc); end
      tests++; if (stall_count !== e.scnt) begin fails++; $display("FAIL en_scnt: got %0d expected %0d", stall_count, e.scnt); end
      tests++; if (flush_count !== e.fcnt) begin fails++; $display("FAIL en_fcnt: got %0d expected %0d", flush_count, e.fcnt); end
    end
    enable = 1'b1; stall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1; reset = 1'b1;
    sb.push_back('{pc:32'h100, ipc:0, ipcn:0, instr:NOP, valid:0, scnt:0, fcnt:0, tout:0});
    tick();
    e = sb.pop_front();
    $display("[TB] reset mid-stall: pc=%h scnt=%0d timeout=%b", pc_out, stall_count, stall_timeout);
    tests++; if (pc_out !== e.pc) begin fails++; $display("FAIL rms_pc: got %h expected %h", pc_out, e.pc); end
    tests++; if (stall_count !== e.scnt) begin fails++; $display("FAIL rms_scnt: got %0d expected %0d", stall_count, e.scnt); end
    tests++; if (flush_count !== e.fcnt) begin fails++; $display("FAIL rms_fcnt: got %0d expected %0d", flush_count, e.fcnt); end
    tests++; if (stall_timeout !== e.tout) begin fails++; $display("FAIL rms_tout: got %b expected %b", stall_timeout, e.tout); end
    reset = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap();
    b_reset = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_bt = 8'h20;
    tick();
    b_reset = 1'b0;
    tests++; if (b_pc !== 8'hF8) begin fails++; $display("FAIL wrap_rst_pc: got %h expected f8", b_pc); end
    sb.push_back('{pc:32'hFC, ipc:32'hF8, ipcn:32'hFC, instr:0, valid:1, scnt:0, fcnt:0, tout:0});
    sb.push_back('{pc:32'h00, ipc:32'hFC, ipcn:32'h00, instr:0, valid:1, scnt:0, fcnt:0, tout:0});
    sb.push_back('{pc:32'h04, ipc:32'h00, ipcn:32'h04, instr:0, valid:1, scnt:0, fcnt:0, tout:0});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      $display("[TB] wrap %0d: pc=%h if_id_pc=%h if_id_pc_next=%h", i, b_pc, b_ipc, b_ipcn);
      tests++; if ({24'h0, b_pc} !== e.pc) begin fails++; $display("FAIL wrap_pc: got %h expected %h", b_pc, e.pc); end
      tests++; if ({24'h0, b_ipc} !== e.ipc) begin fails++; $display("FAIL wrap_ipc: got %h expected %h", b_ipc, e.ipc); end
      tests++; if ({24'h0, b_ipcn} !== e.ipcn) begin fails++; $display("FAIL wrap_ipcn: got %h expected %h", b_ipcn, e.ipcn); end
    end
  endtask

  task automatic test_saturate();
    b_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      sb.push_back('{pc:32'h04, ipc:0, ipcn:0, instr:0, valid:1,
                     scnt:((i < 3) ? 16'(i + 1) : 16'd3), fcnt:0, tout:1});
    for (int i = 0; i < 4; i++)
      sb.push_back('{pc:32'h20, ipc:0, ipcn:0, instr:0, valid:0,
                     scnt:3, fcnt:((i < 3) ? 16'(i + 1) : 16'd3), tout:1});
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 3) begin b_stall = 1'b0; b_flush = 1'b1; end
      e = sb.pop_front();
      $display("[TB] saturate %0d: scnt=%0d fcnt=%0d timeout=%b pc=%h", i, b_scnt, b_fcnt, b_tout, b_pc);
      tests++; if ({14'h0, b_scnt} !== e.scnt) begin fails++; $display("FAIL sat_scnt: got %0d expected %0d", b_scnt, e.scnt); end
      tests++; if ({14'h0, b_fcnt} !== e.fcnt) begin fails++; $display("FAIL sat_fcnt: got %0d expected %0d", b_fcnt, e.fcnt); end
      tests++; if (b_tout !== e.tout) begin fails++; $display("FAIL sat_tout: got %b expected %b", b_tout, e.tout); end
      tests++; if ({24'h0, b_pc} !== e.pc) begin fails++; $display("FAIL sat_pc: got %h expected %h", b_pc, e.pc); end
    end
    b_flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = '0;
    b_reset = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_bt = '0;
    test_reset();
    test_advance();
    test_stall();
    test_flush();
    test_stall_flush();
    test_watchdog();
    test_enable();
    test_reset_mid_stall();
    test_wrap();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
